// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first.
// Define ADDSUB_OVF_EN to build the signed-overflow flag; without it ovf is tied low.
module digit_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    // WIDTH must be an integer multiple of DIGIT.
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] dig_ext;

    assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    always_comb begin
        dig_ext = '0;
        dig_ext[DIGIT-1:0] = dsum[DIGIT-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // New digit enters at the top; after NDIG steps the result is aligned.
                sum_d   = (sum_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = dsum[DIGIT];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ADDSUB_OVF_EN
    logic ovf_q, ovf_d, msb_cin;

    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == SHIFT && cnt_q == LAST) begin
            ovf_d = msb_cin ^ dsum[DIGIT];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub: three configurations checked against an
// arithmetic reference model (W8/D1, W8/D4, W16/D2).
module tb_digit_serial_addsub;
`ifdef ADDSUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        load0 = 1'b0, cin0 = 1'b0, sub0 = 1'b0, busy0, done0, cout0, ovf0;
    logic [7:0]  a0 = '0, b0 = '0, sum0;
    logic        load1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0, busy1, done1, cout1, ovf1;
    logic [7:0]  a1 = '0, b1 = '0, sum1;
    logic        load2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0, busy2, done2, cout2, ovf2;
    logic [15:0] a2 = '0, b2 = '0, sum2;

    int tests_run = 0;
    int tests_failed = 0;

    int cfg_w[3]  = '{8, 8, 16};
    int cfg_nd[3] = '{8, 2, 8};

    digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .reset(reset), .load(load0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));
    digit_serial_addsub #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .reset(reset), .load(load1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
    digit_serial_addsub #(.WIDTH(16), .DIGIT(2)) u2 (
        .clk(clk), .reset(reset), .load(load2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

    // Plain-integer reference: wrapped result, carry / no-borrow, signed-range overflow.
    function automatic void model(input int w, input longint ai, input longint bi,
                                  input bit c, input bit s,
                                  output longint es, output bit ec, output bit eo);
        longint m, r, sa, sb, sr, ci;
        ci = c ? 64'sd1 : 64'sd0;
        m  = longint'(1) << w;
        sa = (ai >= m / 2) ? ai - m : ai;
        sb = (bi >= m / 2) ? bi - m : bi;
        if (s) begin
            r  = ai - bi - ci;
            ec = (r >= 0);
            sr = sa - sb - ci;
        end else begin
            r  = ai + bi + ci;
            ec = (r >= m);
            sr = sa + sb + ci;
        end
        es = ((r % m) + m) % m;
        eo = OVF_EN && ((sr < -(m / 2)) || (sr >= m / 2));
    endfunction

    task automatic drive(input int idx, input longint av, input longint bv,
                         input bit c, input bit s, input bit l);
        case (idx)
            0: begin a0 = av[7:0];  b0 = bv[7:0];  cin0 = c; sub0 = s; load0 = l; end
            1: begin a1 = av[7:0];  b1 = bv[7:0];  cin1 = c; sub1 = s; load1 = l; end
            default: begin a2 = av[15:0]; b2 = bv[15:0]; cin2 = c; sub2 = s; load2 = l; end
        endcase
    endtask

    task automatic sample(input int idx, output bit bz, output bit dn,
                          output longint sm, output bit co, output bit ov);
        case (idx)
            0: begin bz = busy0; dn = done0; sm = longint'(sum0); co = cout0; ov = ovf0; end
            1: begin bz = busy1; dn = done1; sm = longint'(sum1); co = cout1; ov = ovf1; end
            default: begin bz = busy2; dn = done2; sm = longint'(sum2); co = cout2; ov = ovf2; end
        endcase
    endtask

    // Returns at the negedge after the load edge; sync=0 loads in the current cycle.
    task automatic start(input int idx, input longint av, input longint bv,
                         input bit c, input bit s, input bit sync);
        if (sync) @(negedge clk);
        drive(idx, av, bv, c, s, 1'b1);
        @(negedge clk);
        drive(idx, av, bv, c, s, 1'b0);
    endtask

    task automatic wait_done(input int idx, output int cyc, output int bcnt);
        bit bz, dn, co, ov;
        longint sm;
        cyc  = 0;
        bcnt = 0;
        sample(idx, bz, dn, sm, co, ov);
        while (!dn && cyc < 100) begin
            if (bz) bcnt++;
            @(negedge clk);
            cyc++;
            sample(idx, bz, dn, sm, co, ov);
        end
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({busy0, done0, cout0, ovf0} !== 4'b0 || sum0 !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_u0: got busy=%b done=%b sum=%0d cout=%b ovf=%b, expected all 0",
                     busy0, done0, sum0, cout0, ovf0);
        end
        tests_run++;
        if ({busy1, done1, busy2, done2} !== 4'b0 || sum1 !== 8'd0 || sum2 !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_u1u2: got busy1=%b done1=%b sum1=%0d busy2=%b done2=%b sum2=%0d, expected 0",
                     busy1, done1, sum1, busy2, done2, sum2);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int     idx;
        longint a;
        longint b;
        bit     c;
        bit     s;
        longint es;
        bit     ec;
        bit     eo_en;
    } vec_t;

    task automatic test_directed();
        vec_t v[7];
        int cyc, bc;
        bit bz, dn, co, ov;
        longint sm;
        v[0] = '{0, 37, 49, 1'b0, 1'b0, 86, 1'b0, 1'b0};
        v[1] = '{0, 200, 100, 1'b0, 1'b0, 44, 1'b1, 1'b0};
        v[2] = '{0, 100, 100, 1'b0, 1'b0, 200, 1'b0, 1'b1};
        v[3] = '{0, 49, 37, 1'b0, 1'b1, 12, 1'b1, 1'b0};
        v[4] = '{0, 37, 49, 1'b0, 1'b1, 244, 1'b0, 1'b0};
        v[5] = '{1, 37, 49, 1'b0, 1'b0, 86, 1'b0, 1'b0};
        v[6] = '{2, 40000, 30000, 1'b0, 1'b0, 4464, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            start(v[i].idx, v[i].a, v[i].b, v[i].c, v[i].s, 1'b1);
            wait_done(v[i].idx, cyc, bc);
            sample(v[i].idx, bz, dn, sm, co, ov);
            tests_run++;
            if (cyc !== cfg_nd[v[i].idx] || bc !== cfg_nd[v[i].idx]) begin
                tests_failed++;
                $display("FAIL directed%0d_timing: got done after %0d cycles busy %0d, expected %0d/%0d",
                         i, cyc, bc, cfg_nd[v[i].idx], cfg_nd[v[i].idx]);
            end
            tests_run++;
            if (sm !== v[i].es || co !== v[i].ec || ov !== (v[i].eo_en & OVF_EN)) begin
                tests_failed++;
                $display("FAIL directed%0d_result: got sum=%0d cout=%b ovf=%b, expected sum=%0d cout=%b ovf=%b",
                         i, sm, co, ov, v[i].es, v[i].ec, v[i].eo_en & OVF_EN);
            end
        end
    endtask

    task automatic test_hold();
        int cyc, bc;
        start(0, 37, 49, 1'b0, 1'b0, 1'b1);
        wait_done(0, cyc, bc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (done0 !== 1'b0 || busy0 !== 1'b0 || sum0 !== 8'd86 || cout0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold%0d: got done=%b busy=%b sum=%0d cout=%b, expected 0 0 86 0",
                         k, done0, busy0, sum0, cout0);
            end
        end
    endtask

    task automatic test_handshake();
        int cyc, bc;
        start(0, 1, 2, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        drive(0, 9, 9, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 9, 9, 1'b0, 1'b0, 1'b0);
        wait_done(0, cyc, bc);
        tests_run++;
        if (cyc + 3 !== 8 || sum0 !== 8'd3) begin
            tests_failed++;
            $display("FAIL handshake_ignore: got latency=%0d sum=%0d, expected 8 and 3", cyc + 3, sum0);
        end
        start(0, 5, 6, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (busy0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL handshake_done_load: got busy=%b, expected 1", busy0);
        end
        wait_done(0, cyc, bc);
        tests_run++;
        if (cyc !== 8 || sum0 !== 8'd11) begin
            tests_failed++;
            $display("FAIL handshake_second: got latency=%0d sum=%0d, expected 8 and 11", cyc, sum0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bc;
        start(0, 128, 128, 1'b0, 1'b0, 1'b1);
        wait_done(0, cyc, bc);
        start(0, 37, 49, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({busy0, done0, cout0, ovf0} !== 4'b0 || sum0 !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got busy=%b done=%b sum=%0d cout=%b ovf=%b, expected all 0",
                     busy0, done0, sum0, cout0, ovf0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy0, done0);
        end
        start(0, 37, 49, 1'b0, 1'b0, 1'b0);
        wait_done(0, cyc, bc);
        tests_run++;
        if (cyc !== 8 || sum0 !== 8'd86 || cout0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_after: got latency=%0d sum=%0d cout=%b, expected 8 86 0", cyc, sum0, cout0);
        end
    endtask

    task automatic test_random();
        int cyc, bc, idx;
        longint av, bv, es, sm;
        bit c, s, ec, eo, bz, dn, co, ov;
        for (int i = 0; i < 45; i++) begin
            idx = i % 3;
            av  = longint'($urandom_range(0, (1 << cfg_w[idx]) - 1));
            bv  = longint'($urandom_range(0, (1 << cfg_w[idx]) - 1));
            c   = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 1));
            model(cfg_w[idx], av, bv, c, s, es, ec, eo);
            start(idx, av, bv, c, s, 1'b1);
            wait_done(idx, cyc, bc);
            sample(idx, bz, dn, sm, co, ov);
            tests_run++;
            if (cyc !== cfg_nd[idx] || sm !== es || co !== ec || ov !== eo) begin
                tests_failed++;
                $display("FAIL random%0d_u%0d: a=%0d b=%0d cin=%b sub=%b got lat=%0d sum=%0d cout=%b ovf=%b, expected lat=%0d sum=%0d cout=%b ovf=%b",
                         i, idx, av, bv, c, s, cyc, sm, co, ov, cfg_nd[idx], es, ec, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        longint av, bv, es;
        bit c, s, ec, eo;
        av = longint'($urandom_range(0, 255));
        bv = longint'($urandom_range(0, 255));
        c  = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        start(0, av, bv, c, s, 1'b1);
        for (int i = 0; i < 10; i++) begin
            model(8, av, bv, c, s, es, ec, eo);
            wait_done(0, cyc, bc);
            tests_run++;
            if (cyc !== 8 || longint'(sum0) !== es || cout0 !== ec || ovf0 !== eo) begin
                tests_failed++;
                $display("FAIL b2b%0d: a=%0d b=%0d cin=%b sub=%b got lat=%0d sum=%0d cout=%b ovf=%b, expected lat=8 sum=%0d cout=%b ovf=%b",
                         i, av, bv, c, s, cyc, sum0, cout0, ovf0, es, ec, eo);
            end
            av = longint'($urandom_range(0, 255));
            bv = longint'($urandom_range(0, 255));
            c  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            if (i < 9) start(0, av, bv, c, s, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_handshake();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
